// File: rtl/ddr_definitions.sv
// Shared game-state and note encodings for the dance-pad sequencer.
package ddr_definitions;

  localparam int STATE_BITS = 1;
  localparam int NOTE_W     = 2;
  localparam int INDEX_W    = 4;

  typedef enum logic [STATE_BITS:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } game_state_t;

  // Note bits are {left, right}
  localparam logic [NOTE_W-1:0] NOTE_REST = 2'b00;
  localparam logic [NOTE_W-1:0] NOTE_R    = 2'b01;
  localparam logic [NOTE_W-1:0] NOTE_L    = 2'b10;
  localparam logic [NOTE_W-1:0] NOTE_LR   = 2'b11;

endpackage

// File: rtl/note_scheduler_pattern_rom.sv
// pattern_rom: fixed 16-entry arrow pattern, combinational lookup.
import ddr_definitions::*;

module pattern_rom (
  input  logic [INDEX_W-1:0] index,
  output logic [NOTE_W-1:0]  note
);

  always_comb begin
    note = NOTE_REST;
    case (index)
      4'd0:  note = NOTE_L;
      4'd1:  note = NOTE_R;
      4'd2:  note = NOTE_LR;
      4'd3:  note = NOTE_REST;
      4'd4:  note = NOTE_R;
      4'd5:  note = NOTE_L;
      4'd6:  note = NOTE_LR;
      4'd7:  note = NOTE_L;
      4'd8:  note = NOTE_R;
      4'd9:  note = NOTE_REST;
      4'd10: note = NOTE_LR;
      4'd11: note = NOTE_R;
      4'd12: note = NOTE_L;
      4'd13: note = NOTE_LR;
      4'd14: note = NOTE_R;
      4'd15: note = NOTE_L;
      default: note = NOTE_REST;
    endcase
  end

endmodule

// File: rtl/note_scheduler.sv
// Game sequencer: steps the arrow pattern per beat and judges presses per note window.
// Optional feature macro: COMBO_BONUS_EN (hits while combo_en is high score +2).
import ddr_definitions::*;

module note_scheduler #(
  parameter int PATTERN_LEN  = 16,
  parameter int COMBO_THRESH = 4,
  parameter int SCORE_MAX    = 9999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  beat_tick,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  hit_l,
  input  logic                  hit_r,
  output logic [STATE_BITS:0]   state,
  output logic                  lane_l,
  output logic                  lane_r,
  output logic                  hit_pulse,
  output logic                  miss_pulse,
  output logic [7:0]            combo,
  output logic                  combo_en,
  output logic [13:0]           score
);

  localparam logic [INDEX_W-1:0] LAST_IDX    = INDEX_W'(PATTERN_LEN - 1);
  localparam logic [7:0]         THRESH_W    = 8'(COMBO_THRESH);
  localparam logic [14:0]        SCORE_MAX_W = 15'(SCORE_MAX);

  game_state_t        state_q, state_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic               latch_l_q, latch_l_d;
  logic               latch_r_q, latch_r_d;
  logic               judged_q, judged_d;
  logic               hit_d, miss_d;
  logic [7:0]         combo_d;
  logic               combo_en_d;
  logic [13:0]        score_d;
  logic [1:0]         score_inc;
  logic               restart;
  logic [NOTE_W-1:0]  note_cur, note_nxt, lane_d;

  function automatic logic [7:0] sat_combo_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  function automatic logic [13:0] sat_score_add(input logic [13:0] s,
                                                input logic [1:0]  inc);
    logic [14:0] sum;
    sum = {1'b0, s} + {13'd0, inc};
    return (sum > SCORE_MAX_W) ? SCORE_MAX_W[13:0] : sum[13:0];
  endfunction

  // Current note drives judging; the next-index note drives the registered lanes.
  pattern_rom u_rom_cur (.index(index_q), .note(note_cur));
  pattern_rom u_rom_nxt (.index(index_d), .note(note_nxt));

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    latch_l_d = latch_l_q;
    latch_r_d = latch_r_q;
    judged_d  = judged_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    restart   = 1'b0;
    combo_d   = combo_q_get();
    score_d   = score;
    lane_d    = NOTE_REST;
`ifdef COMBO_BONUS_EN
    score_inc = combo_en ? 2'd2 : 2'd1;
`else
    score_inc = 2'd1;
`endif

    case (state_q)
      ST_IDLE:  restart = start && !pause;
      ST_DONE:  restart = start;
      ST_PAUSE: if (!pause) state_d = ST_PLAY;
      ST_PLAY: begin
        if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          // Press is judged before a coincident beat closes the window.
          if (!judged_q && (hit_l || hit_r)) begin
            if ((hit_l && !note_cur[1]) || (hit_r && !note_cur[0])) begin
              miss_d   = 1'b1;
              judged_d = 1'b1;
            end else begin
              latch_l_d = latch_l_q | hit_l;
              latch_r_d = latch_r_q | hit_r;
              if ({latch_l_d, latch_r_d} == note_cur) begin
                hit_d    = 1'b1;
                judged_d = 1'b1;
              end
            end
          end
          if (beat_tick) begin
            if (!judged_d && note_cur != NOTE_REST) miss_d = 1'b1;
            latch_l_d = 1'b0;
            latch_r_d = 1'b0;
            judged_d  = 1'b0;
            if (index_q == LAST_IDX) begin
              state_d = ST_DONE;
              index_d = '0;
            end else begin
              index_d = index_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      state_d   = ST_PLAY;
      index_d   = '0;
      latch_l_d = 1'b0;
      latch_r_d = 1'b0;
      judged_d  = 1'b0;
      combo_d   = 8'd0;
      score_d   = 14'd0;
    end else if (hit_d) begin
      combo_d = sat_combo_inc(combo);
      score_d = sat_score_add(score, score_inc);
    end else if (miss_d) begin
      combo_d = 8'd0;
    end

    combo_en_d = (combo_d >= THRESH_W);
    if (state_d == ST_PLAY || state_d == ST_PAUSE) lane_d = note_nxt;
  end

  function automatic logic [7:0] combo_q_get();
    return combo;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      latch_l_q  <= 1'b0;
      latch_r_q  <= 1'b0;
      judged_q   <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      combo      <= 8'd0;
      combo_en   <= 1'b0;
      score      <= 14'd0;
      lane_l     <= 1'b0;
      lane_r     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      latch_l_q  <= latch_l_d;
      latch_r_q  <= latch_r_d;
      judged_q   <= judged_d;
      hit_pulse  <= hit_d;
      miss_pulse <= miss_d;
      combo      <= combo_d;
      combo_en   <= combo_en_d;
      score      <= score_d;
      lane_l     <= lane_d[1];
      lane_r     <= lane_d[0];
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: vector table through a scoreboard queue, plus combo/saturation and reset sequences.
module tb_note_scheduler;

  localparam int SMAX = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        beat_tick = 1'b0, start = 1'b0, pause = 1'b0;
  logic        hit_l = 1'b0, hit_r = 1'b0;
  logic [1:0]  state;
  logic        lane_l, lane_r, hit_pulse, miss_pulse, combo_en;
  logic [7:0]  combo;
  logic [13:0] score;

  int checks = 0;
  int failures = 0;

  note_scheduler #(.PATTERN_LEN(16), .COMBO_THRESH(4), .SCORE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset), .beat_tick(beat_tick), .start(start), .pause(pause),
    .hit_l(hit_l), .hit_r(hit_r), .state(state), .lane_l(lane_l), .lane_r(lane_r),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .combo(combo),
    .combo_en(combo_en), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, pa, hl, hr, bt;
    logic [1:0] e_state;
    logic [1:0] e_lanes;
    logic       e_hit, e_miss;
    logic [7:0] e_combo;
    logic       e_cen;
    logic [13:0] e_score;
  } row_t;

  row_t rows[$];
  row_t exp_q[$];
  logic [1:0] pat [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic row_t mk(input logic st, pa, hl, hr, bt, input logic [1:0] es,
                              input logic [1:0] el, input logic eh, em,
                              input int ec, input int esc);
    row_t r;
    r.st = st; r.pa = pa; r.hl = hl; r.hr = hr; r.bt = bt;
    r.e_state = es; r.e_lanes = el; r.e_hit = eh; r.e_miss = em;
    r.e_combo = 8'(ec); r.e_cen = (ec >= 4); r.e_score = 14'(esc);
    return r;
  endfunction

  task automatic cyc(input logic st, pa, hl, hr, bt);
    start = st; pause = pa; hit_l = hl; hit_r = hr; beat_tick = bt;
    @(posedge clk); #1;
    start = 0; hit_l = 0; hit_r = 0; beat_tick = 0;
  endtask

  initial begin
    int exp_score, exp_combo, hits, inc;
    logic exp_cen;
    row_t e;
    pat = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10,
            2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};

    //            st pa hl hr bt  state lanes hit miss combo score
    rows.push_back(mk(0,0,0,0,0, 2'd0, 2'b00, 0,0, 0,0));
    rows.push_back(mk(1,0,0,0,0, 2'd1, 2'b10, 0,0, 0,0));
    rows.push_back(mk(0,0,1,0,0, 2'd1, 2'b10, 1,0, 1,1));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b01, 0,0, 1,1));
    rows.push_back(mk(0,0,0,1,0, 2'd1, 2'b01, 1,0, 2,2));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b11, 0,0, 2,2));
    rows.push_back(mk(0,0,1,0,0, 2'd1, 2'b11, 0,0, 2,2));
    rows.push_back(mk(0,0,0,0,0, 2'd1, 2'b11, 0,0, 2,2));
    rows.push_back(mk(0,0,0,1,0, 2'd1, 2'b11, 1,0, 3,3));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b00, 0,0, 3,3));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b01, 0,0, 3,3));
    rows.push_back(mk(0,0,1,1,0, 2'd1, 2'b01, 0,1, 0,3));
    rows.push_back(mk(0,0,0,1,0, 2'd1, 2'b01, 0,0, 0,3));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b10, 0,0, 0,3));
    rows.push_back(mk(0,0,0,1,0, 2'd1, 2'b10, 0,1, 0,3));
    rows.push_back(mk(0,0,1,0,0, 2'd1, 2'b10, 0,0, 0,3));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b11, 0,0, 0,3));
    rows.push_back(mk(0,0,1,0,0, 2'd1, 2'b11, 0,0, 0,3));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b10, 0,1, 0,3));
    rows.push_back(mk(0,1,0,0,0, 2'd2, 2'b10, 0,0, 0,3));
    rows.push_back(mk(0,1,0,0,1, 2'd2, 2'b10, 0,0, 0,3));
    rows.push_back(mk(0,1,1,0,1, 2'd2, 2'b10, 0,0, 0,3));
    rows.push_back(mk(0,1,0,0,1, 2'd2, 2'b10, 0,0, 0,3));
    rows.push_back(mk(0,0,0,0,0, 2'd1, 2'b10, 0,0, 0,3));
    rows.push_back(mk(0,0,1,0,0, 2'd1, 2'b10, 1,0, 1,4));
    rows.push_back(mk(1,0,0,0,0, 2'd1, 2'b10, 0,0, 1,4));
    rows.push_back(mk(0,1,0,0,1, 2'd2, 2'b10, 0,0, 1,4));
    rows.push_back(mk(0,0,0,0,0, 2'd1, 2'b10, 0,0, 1,4));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b01, 0,0, 1,4));
    rows.push_back(mk(0,0,0,1,1, 2'd1, 2'b00, 1,0, 2,5));
    rows.push_back(mk(0,0,1,0,0, 2'd1, 2'b00, 0,1, 0,5));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b11, 0,0, 0,5));
    rows.push_back(mk(0,0,1,1,0, 2'd1, 2'b11, 1,0, 1,6));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b01, 0,0, 1,6));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b10, 0,1, 0,6));
    rows.push_back(mk(0,0,1,0,1, 2'd1, 2'b11, 1,0, 1,7));
    rows.push_back(mk(0,0,1,0,1, 2'd1, 2'b01, 0,1, 0,7));
    rows.push_back(mk(0,0,0,0,1, 2'd1, 2'b10, 0,1, 0,7));
    rows.push_back(mk(0,0,1,0,0, 2'd1, 2'b10, 1,0, 1,8));
    rows.push_back(mk(0,0,0,0,1, 2'd3, 2'b00, 0,0, 1,8));
    rows.push_back(mk(0,0,0,0,0, 2'd3, 2'b00, 0,0, 1,8));
    rows.push_back(mk(0,0,1,0,0, 2'd3, 2'b00, 0,0, 1,8));
    rows.push_back(mk(1,0,0,0,0, 2'd1, 2'b10, 0,0, 0,0));

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_lanes", {lane_l, lane_r}, 0);
    chk("rst_pulses", {hit_pulse, miss_pulse}, 0);
    chk("rst_combo", combo, 0);
    chk("rst_cen", combo_en, 0);
    chk("rst_score", score, 0);
    reset = 1'b0;

    // Vector table through the scoreboard
    for (int i = 0; i < rows.size(); i++) begin
      exp_q.push_back(rows[i]);
      cyc(rows[i].st, rows[i].pa, rows[i].hl, rows[i].hr, rows[i].bt);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_state", i), state, e.e_state);
      chk($sformatf("v%0d_lanes", i), {lane_l, lane_r}, e.e_lanes);
      chk($sformatf("v%0d_hit", i), hit_pulse, e.e_hit);
      chk($sformatf("v%0d_miss", i), miss_pulse, e.e_miss);
      chk($sformatf("v%0d_combo", i), combo, e.e_combo);
      chk($sformatf("v%0d_cen", i), combo_en, e.e_cen);
      chk($sformatf("v%0d_score", i), score, e.e_score);
    end

    // Full pattern of hits: combo threshold, bonus and score saturation
    exp_score = 0; exp_combo = 0; exp_cen = 0; hits = 0;
    for (int i = 0; i < 16; i++) begin
      if (pat[i] != 2'b00) begin
`ifdef COMBO_BONUS_EN
        inc = exp_cen ? 2 : 1;
`else
        inc = 1;
`endif
        exp_score = (exp_score + inc > SMAX) ? SMAX : exp_score + inc;
        exp_combo++;
        exp_cen = (exp_combo >= 4);
        hits++;
        cyc(0, 0, pat[i][1], pat[i][0], 0);
        chk($sformatf("run%0d_hit", i), hit_pulse, 1);
        chk($sformatf("run%0d_combo", i), combo, exp_combo);
        chk($sformatf("run%0d_cen", i), combo_en, exp_cen);
        chk($sformatf("run%0d_score", i), score, exp_score);
        if (hits == 3) chk("cen_after_3", combo_en, 0);
        if (hits == 4) chk("cen_after_4", combo_en, 1);
        if (hits == 6) begin
`ifdef COMBO_BONUS_EN
          chk("score_6_hits", score, 8);
`else
          chk("score_6_hits", score, 6);
`endif
        end
      end
      cyc(0, 0, 0, 0, 1);
      chk($sformatf("run%0d_close", i), {hit_pulse, miss_pulse}, 0);
    end
    chk("run_done", state, 3);
    chk("run_sat", score, SMAX);

    // Async reset mid-game at index 5
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 1);
    chk("pre_rst_lanes", {lane_l, lane_r}, 2'b10);
    chk("pre_rst_score", score, 1);
    reset = 1'b1;
    #2;
    chk("arst_state", state, 0);
    chk("arst_score", score, 0);
    chk("arst_lanes", {lane_l, lane_r}, 0);
    chk("arst_combo", combo, 0);
    @(posedge clk); #1;
    chk("arst_pulses", {hit_pulse, miss_pulse}, 0);
    reset = 1'b0;

    // Start ignored while pause is high in IDLE, then full run to DONE and restart
    cyc(1, 1, 0, 0, 0);
    chk("idle_start_paused", state, 0);
    cyc(1, 0, 0, 0, 0);
    chk("start_play", state, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk($sformatf("idle_run%0d_miss", i), miss_pulse, (pat[i] != 2'b00) ? 1 : 0);
    end
    chk("done_state", state, 3);
    chk("done_lanes", {lane_l, lane_r}, 0);
    cyc(1, 0, 0, 0, 0);
    chk("restart_state", state, 1);
    chk("restart_lanes", {lane_l, lane_r}, 2'b10);
    cyc(0, 0, 0, 0, 1);
    chk("restart_idx1", {lane_l, lane_r}, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Game sequencer for the dance-pad datapath: steps through a fixed arrow pattern on each tempo beat and opens one judge window per note. It judges left/right button presses against the current note and drives the score, combo and game-state outputs consumed by the LED and seven-segment display paths. It replaces the ad-hoc pause/button handling of the state generator with a single owner of game sequencing.

## Interface
- PATTERN_LEN, 16: number of notes played (1..16).
- COMBO_THRESH, 4: combo count at and above which combo_en asserts.
- SCORE_MAX, 9999: score saturation value (fits 14 bits).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- beat_tick  in  1  one-cycle tempo strobe (e.g. 4 Hz enable derived from clk).
- start  in  1  one-cycle start/restart pulse.
- pause  in  1  level pause switch.
- hit_l, hit_r  in  1 each  debounced one-cycle press pulses.
- state  out  STATE_BITS+1 (2)  IDLE=00, PLAY=01, PAUSE=10, DONE=11.
- lane_l, lane_r  out  1 each  current note's arrows.
- hit_pulse, miss_pulse  out  1 each  one-cycle judge results.
- combo  out  8  consecutive hits, saturating at 255.
- combo_en  out  1  combo >= COMBO_THRESH.
- score  out  14  saturating at SCORE_MAX.

## Operation
- Pattern: note[i] is 2 bits {left,right}; 00 = rest. Supplied by the pattern ROM, index 0..PATTERN_LEN-1.
- IDLE: outputs quiet. start with pause low -> PLAY: index=0, score=0, combo=0, window open, judged=0. start with pause high is ignored.
- PLAY: pause high -> PAUSE. In PAUSE, beat_tick and presses are dropped and the window is frozen. pause low -> PLAY. start while in PLAY or PAUSE is ignored.
- Window judging (at most one result per window; judged flag):
  - Press on a lane not in the note (including any press on a rest) -> miss, judged=1.
  - Presses on required lanes are latched per lane. Once all required lanes are latched -> hit, judged=1.
  - Presses after judged=1 are ignored.
  - For note 11, hit_l and hit_r may arrive in the same or different cycles. For a single-lane note, both pressed in the same cycle -> miss.
- beat_tick in PLAY closes the window. A non-rest, unjudged note -> miss. Rest unjudged -> no result. index then advances and lane latches and judged clear. Close after index PATTERN_LEN-1 -> DONE.
- A press and beat_tick in the same cycle: the press is judged first, then the window closes; at most one result is produced.
- Hit: combo += 1 (saturating); score += 1 (see Configuration), saturating at SCORE_MAX. Miss: combo = 0; score unchanged.
- DONE: lanes 0, score/combo hold. start -> PLAY (full restart).
- lane_l/lane_r show note[index] in PLAY and PAUSE, 0 otherwise.

## Timing
- All outputs are registered. Reset values: state=IDLE, lanes=0, hit_pulse=miss_pulse=0, combo=0, combo_en=0, score=0.
- Input event at cycle N -> hit_pulse/miss_pulse, score, combo and combo_en updated at N+1.
- start at N -> state=PLAY and note 0 on lanes at N+1.
- pause change at N -> state change at N+1. beat_tick coincident with the pause rising edge is dropped.
- Final beat_tick at N -> state=DONE at N+1, with miss_pulse at N+1 if applicable.
- reset mid-game returns to IDLE immediately (async); no pulse is emitted.

## Configuration
- COMBO_BONUS_EN defined: a hit while combo_en is already high adds 2 to score (still saturating at SCORE_MAX).
- COMBO_BONUS_EN undefined: every hit adds 1.

## Structure
- ddr_definitions holds STATE_BITS, the IDLE/PLAY/PAUSE/DONE encodings and the note encoding constants.
- Sub-module pattern_rom: combinational, 4-bit index in, 2-bit note out, with the 16-entry table. note_scheduler instantiates it.

## Test plan
- Reset, start, pattern {10,01,11,00,…}; press the correct lane(s) once per beat -> hit_pulse per non-rest note, score=3 after three non-rest notes, combo=3, rest produces no pulse.
- Note 10, press hit_r -> miss_pulse at N+1, combo=0; a later hit_l in the same window -> no pulse.
- Note 11, hit_l then hit_r two cycles later -> single hit_pulse one cycle after hit_r. No press before beat_tick -> miss_pulse.
- pause high mid-window with 3 beat_ticks -> index and lanes unchanged, no pulses. pause low then correct press -> hit.
- Six consecutive hits with COMBO_THRESH=4: combo_en high after the 4th hit. With COMBO_BONUS_EN, score=4+2+2=8; without it, score=6. Force score to 9998 with bonus active -> score=9999.
- Assert reset in PLAY at index 5 -> state=00, score=0, lanes=0 immediately. Run all PATTERN_LEN beats -> state=DONE; start -> PLAY at index 0.
